demod_integrate_classify: RTL

Parametrised multi-channel integrate-and-classify engine for the demodulation chain. It takes NCH pairs of I/Q five-lane sample streams and accumulates each channel over a programmable window after a trigger. Each channel's integrated point is then classified against a per-channel discrimination line. Results go out on the standard five-lane output stream, either as one beat per channel or as one packed beat.

---
 rtl/demod_pkg.sv | 38 +++
 rtl/demod_integrate_classify_if.sv | 12 +
 rtl/demod_chan_acc.sv | 110 +++++++++++
 rtl/demod_integrate_classify.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/demod_pkg.sv
// Shared types and constants for the demodulation integrate-and-classify block:
// FSM encoding, config address map and the result flag-lane layout.
package demod_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_INTEG  = 3'd1,
        ST_MULT   = 3'd2,
        ST_DECIDE = 3'd3,
        ST_EMIT   = 3'd4
    } demod_state_e;

    localparam logic [13:0] ADDR_CTRL    = 14'h0000;
    localparam logic [13:0] ADDR_NCYC    = 14'h0001;
    localparam logic [13:0] ADDR_CH_BASE = 14'h0010;
    localparam int          CH_STRIDE    = 4;

    localparam int D4_OVR_BIT   = 15;
    localparam int D4_SAT_BIT   = 14;
    localparam int D4_CH_LSB    = 1;
    localparam int D4_STATE_BIT = 0;

    function automatic logic [13:0] ch_addr(input int c, input int sel);
        return ADDR_CH_BASE + 14'(CH_STRIDE * c + sel);
    endfunction

    function automatic logic [15:0] pack_flags(input logic ovr, input logic sat,
                                               input logic [6:0] ch, input logic st);
        logic [15:0] f;
        f                    = 16'h0000;
        f[D4_OVR_BIT]        = ovr;
        f[D4_SAT_BIT]        = sat;
        f[D4_CH_LSB +: 7]    = ch;
        f[D4_STATE_BIT]      = st;
        return f;
    endfunction

endpackage

// File: rtl/demod_integrate_classify_if.sv
// Five-lane result stream (no backpressure) driven by the classifier.
interface demod_integrate_classify_if;
    logic [15:0] data_0;
    logic [15:0] data_1;
    logic [15:0] data_2;
    logic [15:0] data_3;
    logic [15:0] data_4;
    logic        valid;

    modport master (output data_0, data_1, data_2, data_3, data_4, valid);
    modport slave  (input  data_0, data_1, data_2, data_3, data_4, valid);
endinterface

// File: rtl/demod_chan_acc.sv
// One channel: lane adder, saturating I/Q accumulators with sticky sat flag,
// and the two-stage offset/project/sign pipeline that yields the state bit.
module demod_chan_acc
    import demod_pkg::*;
#(
    parameter int LANES  = 5,
    parameter int SAMP_W = 16,
    parameter int ACC_W  = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_clear,
    input  logic                      i_acc_en,
    input  logic                      i_mult,
    input  logic                      i_decide,
    input  logic [LANES*SAMP_W-1:0]   i_lanes_i,
    input  logic [LANES*SAMP_W-1:0]   i_lanes_q,
    input  logic signed [ACC_W-1:0]   i_i_pt,
    input  logic signed [ACC_W-1:0]   i_q_pt,
    input  logic signed [15:0]        i_i_perp,
    input  logic signed [15:0]        i_q_perp,
    output logic signed [ACC_W-1:0]   o_acc_i,
    output logic signed [ACC_W-1:0]   o_acc_q,
    output logic                      o_sat,
    output logic                      o_state
);
    localparam int SUM_W  = SAMP_W + $clog2(LANES);
    localparam int EXT_W  = ACC_W + 1;
    localparam int PROD_W = ACC_W + 17;
    localparam int DOT_W  = ACC_W + 18;

    // Top bit of the result flags an overflow; the rest is the clipped value.
    function automatic logic [ACC_W:0] sat_clip(input logic [ACC_W:0] s);
        logic [ACC_W:0] r;
        if (s[ACC_W] != s[ACC_W-1]) begin
            r = {1'b1, s[ACC_W], {(ACC_W-1){~s[ACC_W]}}};
        end else begin
            r = {1'b0, s[ACC_W-1:0]};
        end
        return r;
    endfunction

    logic signed [SUM_W-1:0]  w_lsum_i, w_lsum_q;
    logic signed [EXT_W-1:0]  w_sum_i, w_sum_q, w_di, w_dq;
    logic        [ACC_W:0]    w_clip_i, w_clip_q;
    logic signed [DOT_W-1:0]  w_dot;
    logic                     w_dot_pos;
    logic signed [ACC_W-1:0]  r_acc_i, r_acc_q;
    logic signed [PROD_W-1:0] r_pi, r_pq;
    logic                     r_sat, r_state;

    always_comb begin
        w_lsum_i = '0;
        w_lsum_q = '0;
        for (int k = 0; k < LANES; k++) begin
            w_lsum_i = w_lsum_i + SUM_W'($signed(i_lanes_i[k*SAMP_W +: SAMP_W]));
            w_lsum_q = w_lsum_q + SUM_W'($signed(i_lanes_q[k*SAMP_W +: SAMP_W]));
        end
    end

    assign w_sum_i   = EXT_W'(r_acc_i) + EXT_W'(w_lsum_i);
    assign w_sum_q   = EXT_W'(r_acc_q) + EXT_W'(w_lsum_q);
    assign w_clip_i  = sat_clip(w_sum_i);
    assign w_clip_q  = sat_clip(w_sum_q);
    assign w_di      = EXT_W'(r_acc_i) - EXT_W'(i_i_pt);
    assign w_dq      = EXT_W'(r_acc_q) - EXT_W'(i_q_pt);
    assign w_dot     = DOT_W'(r_pi) + DOT_W'(r_pq);
    assign w_dot_pos = ~w_dot[DOT_W-1] & (|w_dot);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc_i <= '0;
            r_acc_q <= '0;
            r_sat   <= 1'b0;
        end else if (i_clear) begin
            r_acc_i <= '0;
            r_acc_q <= '0;
            r_sat   <= 1'b0;
        end else if (i_acc_en) begin
            r_acc_i <= w_clip_i[ACC_W-1:0];
            r_acc_q <= w_clip_q[ACC_W-1:0];
            r_sat   <= r_sat | w_clip_i[ACC_W] | w_clip_q[ACC_W];
        end
    end

    // Projection onto the discrimination normal; its sign is the class.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pi    <= '0;
            r_pq    <= '0;
            r_state <= 1'b0;
        end else if (i_clear) begin
            r_pi    <= '0;
            r_pq    <= '0;
            r_state <= 1'b0;
        end else if (i_mult) begin
            r_pi <= PROD_W'(w_di) * PROD_W'(i_i_perp);
            r_pq <= PROD_W'(w_dq) * PROD_W'(i_q_perp);
        end else if (i_decide) begin
            r_state <= w_dot_pos;
        end
    end

    assign o_acc_i = r_acc_i;
    assign o_acc_q = r_acc_q;
    assign o_sat   = r_sat;
    // The first result beat is built during DECIDE, so expose the live decision there.
    assign o_state = i_decide ? w_dot_pos : r_state;

endmodule

// File: rtl/demod_integrate_classify.sv
// Multi-channel integrate-and-classify engine: config registers and shadows,
// trigger edge detect, measurement FSM, window counter and result stream mux.
module demod_integrate_classify
    import demod_pkg::*;
#(
    parameter int NCH    = 2,
    parameter int LANES  = 5,
    parameter int SAMP_W = 16,
    parameter int ACC_W  = 32,
    parameter int CNT_W  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [13:0]                   MEM_sdi_mem_S_address,
    input  logic                          MEM_sdi_mem_S_wrEn,
    input  logic [31:0]                   MEM_sdi_mem_S_wrData,
    input  logic                          trigger_in,
    input  logic [NCH*LANES*SAMP_W-1:0]   data_i_in,
    input  logic [NCH*LANES*SAMP_W-1:0]   data_q_in,
    input  logic                          data_in_valid,
    demod_integrate_classify_if.master    data_out_sdi_dataStreamFCx5_M,
    output logic [4:0]                    trigger_out
);
    localparam int BEAT_W = (NCH > 1) ? $clog2(NCH) : 1;

    logic                    r_mode, r_ovr, r_trig_prev;
    logic [CNT_W-1:0]        r_ncyc;
    logic signed [ACC_W-1:0] r_i_pt [NCH];
    logic signed [ACC_W-1:0] r_q_pt [NCH];
    logic signed [15:0]      r_i_perp [NCH];
    logic signed [15:0]      r_q_perp [NCH];

    logic                    r_sh_mode;
    logic [CNT_W-1:0]        r_sh_ncyc;
    logic signed [ACC_W-1:0] r_sh_i_pt [NCH];
    logic signed [ACC_W-1:0] r_sh_q_pt [NCH];
    logic signed [15:0]      r_sh_i_perp [NCH];
    logic signed [15:0]      r_sh_q_perp [NCH];

    demod_state_e            r_state, w_next;
    logic [CNT_W-1:0]        r_cnt;
    logic [BEAT_W-1:0]       r_beat, w_sel;
    logic [4:0][15:0]        r_o_data, w_o_data;
    logic                    r_o_valid, r_o_first;

    logic                    w_trig_edge, w_start, w_last_beat, w_emit_done, w_load;
    logic                    w_ctrl_wr;
    logic signed [ACC_W-1:0] w_acc_i [NCH];
    logic signed [ACC_W-1:0] w_acc_q [NCH];
    logic [NCH-1:0]          w_sat, w_st;
    logic [31:0]             w_i32, w_q32;
    logic                    w_sel_sat, w_sel_st;
    logic                    w_unused;

    assign w_trig_edge = trigger_in & ~r_trig_prev;
    assign w_start     = w_trig_edge && (r_state == ST_IDLE);
    assign w_ctrl_wr   = MEM_sdi_mem_S_wrEn && (MEM_sdi_mem_S_address == ADDR_CTRL);
    assign w_last_beat = (r_state == ST_INTEG) && data_in_valid
                         && (r_cnt == r_sh_ncyc - CNT_W'(1));
    assign w_emit_done = r_sh_mode || (r_beat == BEAT_W'(NCH - 1));
    assign w_load      = (r_state == ST_DECIDE) || ((r_state == ST_EMIT) && !w_emit_done);
    assign w_sel       = (r_state == ST_DECIDE) ? '0 : r_beat + BEAT_W'(1);
    assign w_unused    = ^MEM_sdi_mem_S_wrData;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode <= 1'b0;
            r_ncyc <= CNT_W'(1);
            for (int c = 0; c < NCH; c++) begin
                r_i_pt[c]   <= '0;
                r_q_pt[c]   <= '0;
                r_i_perp[c] <= '0;
                r_q_perp[c] <= '0;
            end
        end else if (MEM_sdi_mem_S_wrEn) begin
            if (MEM_sdi_mem_S_address == ADDR_CTRL) r_mode <= MEM_sdi_mem_S_wrData[0];
            if (MEM_sdi_mem_S_address == ADDR_NCYC) r_ncyc <= MEM_sdi_mem_S_wrData[CNT_W-1:0];
            for (int c = 0; c < NCH; c++) begin
                if (MEM_sdi_mem_S_address == ch_addr(c, 0)) r_i_pt[c]   <= MEM_sdi_mem_S_wrData[ACC_W-1:0];
                if (MEM_sdi_mem_S_address == ch_addr(c, 1)) r_q_pt[c]   <= MEM_sdi_mem_S_wrData[ACC_W-1:0];
                if (MEM_sdi_mem_S_address == ch_addr(c, 2)) r_i_perp[c] <= MEM_sdi_mem_S_wrData[15:0];
                if (MEM_sdi_mem_S_address == ch_addr(c, 3)) r_q_perp[c] <= MEM_sdi_mem_S_wrData[15:0];
            end
        end
    end

    // Shadows see the pre-write config when a write and a trigger coincide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sh_mode <= 1'b0;
            r_sh_ncyc <= '0;
            for (int c = 0; c < NCH; c++) begin
                r_sh_i_pt[c]   <= '0;
                r_sh_q_pt[c]   <= '0;
                r_sh_i_perp[c] <= '0;
                r_sh_q_perp[c] <= '0;
            end
        end else if (w_start) begin
            r_sh_mode <= r_mode;
            r_sh_ncyc <= (r_ncyc == '0) ? CNT_W'(1) : r_ncyc;
            for (int c = 0; c < NCH; c++) begin
                r_sh_i_pt[c]   <= r_i_pt[c];
                r_sh_q_pt[c]   <= r_q_pt[c];
                r_sh_i_perp[c] <= r_i_perp[c];
                r_sh_q_perp[c] <= r_q_perp[c];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_trig_prev <= 1'b0;
            r_ovr       <= 1'b0;
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_beat      <= '0;
        end else begin
            r_trig_prev <= trigger_in;
            r_state     <= w_next;
            if (w_trig_edge && (r_state != ST_IDLE)) r_ovr <= 1'b1;
            else if (w_ctrl_wr && MEM_sdi_mem_S_wrData[1]) r_ovr <= 1'b0;
            if (w_start) r_cnt <= '0;
            else if ((r_state == ST_INTEG) && data_in_valid) r_cnt <= r_cnt + CNT_W'(1);
            if (r_state == ST_DECIDE) r_beat <= '0;
            else if (r_state == ST_EMIT) r_beat <= r_beat + BEAT_W'(1);
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_start) w_next = ST_INTEG; else w_next = ST_IDLE;
            ST_INTEG:  if (w_last_beat) w_next = ST_MULT; else w_next = ST_INTEG;
            ST_MULT:   w_next = ST_DECIDE;
            ST_DECIDE: w_next = ST_EMIT;
            ST_EMIT:   if (w_emit_done) w_next = ST_IDLE; else w_next = ST_EMIT;
            default:   w_next = ST_IDLE;
        endcase
    end

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        demod_chan_acc #(
            .LANES  (LANES),
            .SAMP_W (SAMP_W),
            .ACC_W  (ACC_W)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .i_clear   (w_start),
            .i_acc_en  ((r_state == ST_INTEG) && data_in_valid),
            .i_mult    (r_state == ST_MULT),
            .i_decide  (r_state == ST_DECIDE),
            .i_lanes_i (data_i_in[c*LANES*SAMP_W +: LANES*SAMP_W]),
            .i_lanes_q (data_q_in[c*LANES*SAMP_W +: LANES*SAMP_W]),
            .i_i_pt    (r_sh_i_pt[c]),
            .i_q_pt    (r_sh_q_pt[c]),
            .i_i_perp  (r_sh_i_perp[c]),
            .i_q_perp  (r_sh_q_perp[c]),
            .o_acc_i   (w_acc_i[c]),
            .o_acc_q   (w_acc_q[c]),
            .o_sat     (w_sat[c]),
            .o_state   (w_st[c])
        );
    end

    // Next result beat, built one cycle ahead so the stream lanes are registered.
    always_comb begin
        w_o_data  = '0;
        w_i32     = '0;
        w_q32     = '0;
        w_sel_sat = 1'b0;
        w_sel_st  = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            if (BEAT_W'(c) == w_sel) begin
                w_i32     = 32'(w_acc_i[c]);
                w_q32     = 32'(w_acc_q[c]);
                w_sel_sat = w_sat[c];
                w_sel_st  = w_st[c];
            end
        end
        if (!w_load) begin
            w_o_data = '0;
        end else if (r_sh_mode) begin
            w_o_data[0] = 16'(w_st);
            w_o_data[1] = 16'(w_sat);
            w_o_data[4] = pack_flags(r_ovr, 1'b0, 7'd0, 1'b0);
        end else begin
            w_o_data[0] = w_i32[15:0];
            w_o_data[1] = w_i32[31:16];
            w_o_data[2] = w_q32[15:0];
            w_o_data[3] = w_q32[31:16];
            w_o_data[4] = pack_flags(r_ovr, w_sel_sat, 7'(w_sel), w_sel_st);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_o_data  <= '0;
            r_o_valid <= 1'b0;
            r_o_first <= 1'b0;
        end else begin
            r_o_data  <= w_o_data;
            r_o_valid <= w_load;
            r_o_first <= (r_state == ST_DECIDE);
        end
    end

    assign data_out_sdi_dataStreamFCx5_M.data_0 = r_o_data[0];
    assign data_out_sdi_dataStreamFCx5_M.data_1 = r_o_data[1];
    assign data_out_sdi_dataStreamFCx5_M.data_2 = r_o_data[2];
    assign data_out_sdi_dataStreamFCx5_M.data_3 = r_o_data[3];
    assign data_out_sdi_dataStreamFCx5_M.data_4 = r_o_data[4];
    assign data_out_sdi_dataStreamFCx5_M.valid  = r_o_valid;
    assign trigger_out = {3'b000, r_o_first, r_o_valid};

endmodule
